clock_ctrl: RTL
===============

Name: clock_ctrl

Overview:
- Time-of-day controller for the lab digital clock. Sequences four chained BCD digit counters (MM:SS, 00:00–59:59) from a one-second prescaler.
- Provides a set-mode state machine so the user can adjust minutes and seconds with two push-button pulses.
- Sits between the board button conditioners (single-cycle pulses) and the 7-segment display driver.

Parameters:
- TICK_DIV, 50000000: clk cycles per one-second tick; minimum 4, must be even.
- PW, $clog2(TICK_DIV): prescaler width, derived, not overridden.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- run_en  in  1  level; when low, timekeeping pauses in RUN and the prescaler holds
- mode_btn  in  1  single-cycle pulse; advances the set-mode FSM
- inc_btn  in  1  single-cycle pulse; increments the selected field in set modes
- sec_lo  out  4  seconds units, 0–9
- sec_hi  out  3  seconds tens, 0–5
- min_lo  out  4  minutes units, 0–9
- min_hi  out  3  minutes tens, 0–5
- mode  out  2  current state: 0=RUN, 1=SET_MIN, 2=SET_SEC
- blink  out  1  display blink enable for the selected field
- hour_co  out  1  one-cycle pulse on 59:59→00:00 rollover

Behaviour:
- Reset: all digits 0, mode=RUN, prescaler=0, blink=0, hour_co=0. Reset applies mid-operation in any state and takes priority over every input.
- Prescaler, RUN state:
  - Counts 0..TICK_DIV-1 when run_en=1; holds its value when run_en=0.
  - Internal tick is asserted in the cycle the prescaler equals TICK_DIV-1 and run_en=1; the prescaler wraps to 0 in the same edge.
- Time increment on tick:
  - Digits update at the same clock edge, so displayed time changes 1 cycle after the tick cycle.
  - Carry chain is combinational and ripples in one cycle: sec_lo 9→0 carries into sec_hi; sec_hi 5→0 carries into min_lo; min_lo 9→0 carries into min_hi; min_hi 5→0 wraps.
  - 59:59→00:00 registers hour_co=1 for exactly one cycle; hour_co=0 otherwise.
- FSM transitions on mode_btn: RUN→SET_MIN→SET_SEC→RUN. No other transitions exist; the unused encoding 3 returns to RUN on the next edge.
- Entering SET_MIN from RUN: prescaler cleared to 0, then free-runs 0..TICK_DIV-1 regardless of run_en. No tick or time advance occurs in any set state.
- Returning to RUN: prescaler cleared to 0, so the first tick arrives TICK_DIV cycles after the mode_btn edge, if run_en=1.
- SET_MIN with inc_btn: minutes increment mod 60 (59→00). There is no carry anywhere and hour_co stays 0. Seconds are unchanged.
- SET_SEC with inc_btn: seconds increment mod 60 (59→00). There is no carry into minutes and hour_co stays 0.
- inc_btn in RUN: ignored.
- mode_btn and inc_btn in the same cycle: mode transition taken, inc ignored.
- blink:
  - RUN: 0.
  - Set states: 1 while prescaler < TICK_DIV/2, else 0, giving a 1 Hz 50% duty cycle.
- Outputs are all registered. No combinational path from inputs to outputs.

Decomposition:
- Package clock_ctrl_pkg holds:
  - State encoding constants ST_RUN=2'd0, ST_SET_MIN=2'd1, ST_SET_SEC=2'd2.
  - Digit limits LIM_LO=9, LIM_HI=5.
- Sub-module bcd_digit, instantiated four times:
  - Parameter MAX; ports clk, rst, en, q, co.
  - Synchronous reset to 0; increments on en; wraps MAX→0.
  - co is combinational (en && q==MAX) so carries chain within one cycle.
- Set-mode increments drive the en inputs of the digit pair with an internally gated chain, so the carry from sec_hi/min_hi is blocked in set states.
- FSM and prescaler live in clock_ctrl.

Test Plan:
- TICK_DIV=4. Reset, run_en=1, run 240 cycles → time 01:00; tick every 4th cycle; hour_co never high.
- Preload 59:58 via set mode, return to RUN, run 8 cycles → 59:59 then 00:00; hour_co high exactly 1 cycle, coincident with the 00:00 update.
- RUN at 00:05, drop run_en for 20 cycles → time and prescaler frozen. Raise run_en → the next tick resumes from the held prescaler value.
- mode_btn ×1, inc_btn ×61 at 12:34 → mode=1, minutes wrap 12→59→00→13, seconds stay 34, hour_co stays 0. Blink toggles every 2 cycles.
- In SET_SEC at 00:59, mode_btn and inc_btn in the same cycle → mode=RUN, time stays 00:59, first tick 4 cycles later gives 01:00.
- Assert rst during SET_SEC at 33:21 → next cycle all digits 0, mode=RUN, blink=0, hour_co=0.

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
// ============================================================================
// clock_ctrl_pkg : state encodings and BCD digit limits for clock_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package clock_ctrl_pkg;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_SET_MIN = 2'd1;
  localparam logic [1:0] ST_SET_SEC = 2'd2;

  localparam int LIM_LO = 9;
  localparam int LIM_HI = 5;

  typedef enum logic [1:0] {
    S_RUN     = ST_RUN,
    S_SET_MIN = ST_SET_MIN,
    S_SET_SEC = ST_SET_SEC,
    S_UNUSED  = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/clock_ctrl_bcd_digit.sv
// ============================================================================
// bcd_digit : single wrapping decimal digit with combinational carry-out
// Rev 1.0
// ============================================================================
`default_nettype none

module bcd_digit #(
  parameter int MAX = 9,
  parameter int W   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         co
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = (cnt_q == W'(MAX)) ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q  = cnt_q;
  // Carry is unregistered so a whole MM:SS ripple settles in one cycle.
  assign co = en && (cnt_q == W'(MAX));

endmodule

`default_nettype wire

// File: rtl/clock_ctrl.sv
// ============================================================================
// clock_ctrl : MM:SS time-of-day counter with one-second prescaler and set FSM
// Rev 1.0
// ============================================================================
`default_nettype none

module clock_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_en,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [3:0] sec_lo,
  output logic [2:0] sec_hi,
  output logic [3:0] min_lo,
  output logic [2:0] min_hi,
  output logic [1:0] mode,
  output logic       blink,
  output logic       hour_co
);

  localparam int            PW      = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRE_HALF = PW'(TICK_DIV / 2);

  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          blink_q, blink_d;
  logic          hour_co_q, hour_co_d;
  logic          tick;
  logic [PW-1:0] pre_wrap;

  logic en_sl, en_sh, en_ml, en_mh;
  logic co_sl, co_sh, co_ml, co_mh;
  logic in_run, in_set_min, in_set_sec, inc_ok;

  assign in_run     = (state_q == S_RUN);
  assign in_set_min = (state_q == S_SET_MIN);
  assign in_set_sec = (state_q == S_SET_SEC);
  assign inc_ok     = inc_btn && !mode_btn;
  assign pre_wrap   = (pre_q == PRE_MAX) ? '0 : pre_q + PW'(1);
  assign tick       = in_run && run_en && (pre_q == PRE_MAX);

  // Set-mode increments enter at the field's low digit; the inter-field
  // carries are only honoured in RUN so adjusting never disturbs the other field.
  assign en_sl = tick || (in_set_sec && inc_ok);
  assign en_sh = co_sl;
  assign en_ml = (in_run && co_sh) || (in_set_min && inc_ok);
  assign en_mh = co_ml;

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    case (state_q)
      S_RUN: begin
        if (run_en) begin
          pre_d = pre_wrap;
        end
        if (mode_btn) begin
          state_d = S_SET_MIN;
          pre_d   = '0;
        end
      end
      S_SET_MIN: begin
        pre_d = pre_wrap;
        if (mode_btn) begin
          state_d = S_SET_SEC;
        end
      end
      S_SET_SEC: begin
        pre_d = pre_wrap;
        if (mode_btn) begin
          state_d = S_RUN;
          pre_d   = '0;
        end
      end
      default: begin
        state_d = S_RUN;
        pre_d   = '0;
      end
    endcase
    hour_co_d = in_run && co_mh;
    blink_d   = ((state_d == S_SET_MIN) || (state_d == S_SET_SEC)) && (pre_d < PRE_HALF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_RUN;
      pre_q     <= '0;
      blink_q   <= 1'b0;
      hour_co_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      blink_q   <= blink_d;
      hour_co_q <= hour_co_d;
    end
  end

  bcd_digit #(.MAX(LIM_LO), .W(4)) u_sec_lo (
    .clk(clk), .rst(rst), .en(en_sl), .q(sec_lo), .co(co_sl)
  );
  bcd_digit #(.MAX(LIM_HI), .W(3)) u_sec_hi (
    .clk(clk), .rst(rst), .en(en_sh), .q(sec_hi), .co(co_sh)
  );
  bcd_digit #(.MAX(LIM_LO), .W(4)) u_min_lo (
    .clk(clk), .rst(rst), .en(en_ml), .q(min_lo), .co(co_ml)
  );
  bcd_digit #(.MAX(LIM_HI), .W(3)) u_min_hi (
    .clk(clk), .rst(rst), .en(en_mh), .q(min_hi), .co(co_mh)
  );

  assign mode    = state_q;
  assign blink   = blink_q;
  assign hour_co = hour_co_q;

endmodule

`default_nettype wire
